mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single-port 64-bit unified memory between three requesters:
  - the UART program loader (write-only);
  - the CPU data port (load/store);
  - the CPU instruction fetch.
- Performs fixed-priority arbitration with fetch anti-starvation.
- Registers the memory command and tags in-flight reads so read data returns to the correct requester.
- Sits between the core/loader and the memory in top.

Parameters:
- ADDR_W, 8, memory byte-address width (matches the addr/pclow width in top).
- MEM_LAT, 1, memory read latency in cycles from registered mem_en to mem_rdata valid (1..4).
- STARVE_LIMIT, 4, consecutive denied cycles of i_req before fetch outranks the data port (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- ld_req  in  1  loader write request.
- ld_addr  in  ADDR_W  loader byte address.
- ld_wdata  in  64  loader write data.
- ld_we  in  2  loader write type; 00 is illegal while ld_req=1.
- ld_gnt  out  1  loader request accepted this cycle.
- d_req  in  1  data-port request.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  64  store data.
- d_we  in  2  memwrite encoding: 00 = load, else store type.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  load data valid.
- d_rdata  out  64  load data.
- i_req  in  1  fetch request.
- i_addr  in  ADDR_W  fetch byte address, word-aligned.
- i_gnt  out  1  fetch accepted this cycle.
- i_rvalid  out  1  instruction valid.
- i_rdata  out  32  instruction word.
- mem_en  out  1  memory access strobe (registered).
- mem_addr  out  ADDR_W  memory address (registered).
- mem_wdata  out  64  memory write data (registered).
- mem_we  out  2  memory write type (registered); 00 = read.
- mem_rdata  in  64  memory read data, valid MEM_LAT cycles after a read strobe.
- busy  out  1  any read in flight or mem_en high.

Behaviour:
- Reset values: all outputs 0, tag pipeline cleared, starve_cnt = 0, boost = 0.
  - Reads in flight at reset are discarded; no rvalid is issued for them, even if mem_rdata arrives later.
- Arbitration is combinational, one winner per cycle, no idle cycles between grants.
  - Default priority: loader > data > fetch.
  - When boost = 1: loader > fetch > data.
- Grant rules:
  - gnt is a single-cycle pulse in the cycle of acceptance.
  - The requester holds req, addr, wdata and we stable until it sees gnt.
  - It may present a new request in the cycle after gnt.
- Command register: in the cycle after grant, mem_en = 1 and mem_addr/mem_wdata/mem_we carry the winner's values.
  - With no winner, mem_en = 0 and the other mem_* outputs hold their previous values.
  - Fetch and data loads drive mem_we = 00; fetch drives mem_wdata = 0.
- Read tagging: a depth-MEM_LAT shift pipeline carries {valid, owner, addr bit 2} for each read strobe.
  - Data read: d_rvalid = 1 and d_rdata = mem_rdata exactly MEM_LAT cycles after mem_en.
  - Fetch read: i_rvalid = 1 at the same point; i_rdata = mem_rdata[31:0] if addr bit 2 = 0, else mem_rdata[63:32].
  - Total load latency: gnt at cycle t -> rvalid at cycle t+1+MEM_LAT.
  - Back-to-back reads from any mix of owners complete in grant order, one per cycle.
  - Writes produce no rvalid.
- Anti-starvation:
  - starve_cnt increments in each cycle where i_req = 1 and i_gnt = 0.
  - starve_cnt clears when i_gnt = 1 or i_req = 0.
  - boost is set when starve_cnt reaches STARVE_LIMIT.
  - boost clears together with starve_cnt.
  - The loader always outranks fetch, even under boost.
- Simultaneous grant and read return: a new grant may coexist with rvalid in the same cycle; the two are independent.
- Address alignment: i_addr[1:0] != 00 is ignored (bits dropped). The arbiter does not check d_addr alignment.
- busy = mem_en OR any valid bit in the tag pipeline.

Test Plan:
- Reset:
  - Stimulus: hold reset for 3 cycles with all requests high.
  - Required response: all gnt, rvalid and mem_en = 0; first gnt is ld_gnt in the cycle after reset falls.
- Single fetch, MEM_LAT=1:
  - Stimulus: i_req at cycle 10, i_addr = 0x04; memory holds 0x11112222_33334444 at word 0.
  - Required response: i_gnt at 10, mem_en/mem_addr = 0x04 at 11, i_rvalid at 12 with i_rdata = 0x11112222.
- Priority:
  - Stimulus: ld_req, d_req and i_req all high at the same cycle.
  - Required response: grant order over three cycles is ld, d, i; mem_we = ld_we, then d_we, then 00.
- Starvation, STARVE_LIMIT=4:
  - Stimulus: d_req and i_req held continuously.
  - Required response: d_gnt on 4 consecutive cycles, then i_gnt on the 5th, then d_gnt resumes; starve_cnt returns to 0.
- Read ordering, MEM_LAT=2:
  - Stimulus: alternate d loads (addr 0x08, 0x10) and fetches (0x00, 0x04) on consecutive cycles.
  - Required response: rvalids return in grant order, each tagged to the correct port, with fetch halves selected per addr bit 2.
- Reset mid-read:
  - Stimulus: assert reset one cycle after a d load mem_en.
  - Required response: no d_rvalid ever appears for that load; busy = 0 the cycle after reset.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_arbiter                                                         |
// | Loader/data/fetch arbiter for the unified 64-bit single-port memory,     |
// | with fetch anti-starvation and tagged read-data return.                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_port_arbiter #(
   parameter int ADDR_W       = 8,
   parameter int MEM_LAT      = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ld_req,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [63:0]       ld_wdata,
   input  logic [1:0]        ld_we,
   output logic              ld_gnt,
   input  logic              d_req,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [63:0]       d_wdata,
   input  logic [1:0]        d_we,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [63:0]       d_rdata,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [31:0]       i_rdata,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [63:0]       mem_wdata,
   output logic [1:0]        mem_we,
   input  logic [63:0]       mem_rdata,
   output logic              busy
);

   localparam logic [ADDR_W-1:0] c_fetch_mask   = ~ADDR_W'(3);
   localparam logic [3:0]        c_starve_limit = 4'(STARVE_LIMIT);

   logic              w_ld_win, w_d_win, w_i_win, w_any_win;
   logic [3:0]        r_starve_cnt, w_starve_next;
   logic              r_boost;
   logic              r_mem_en;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [63:0]       r_mem_wdata;
   logic [1:0]        r_mem_we;
   logic              r_owner_fetch;
   logic [MEM_LAT-1:0] r_tag_v, r_tag_f, r_tag_hi;
   logic              w_tag_in_v, w_ret_v;

   // Boost only swaps data and fetch; the loader always wins.
   always_comb begin
      w_ld_win  = ~reset & ld_req;
      w_i_win   = ~reset & ~ld_req & i_req & (r_boost | ~d_req);
      w_d_win   = ~reset & ~ld_req & d_req & ~(r_boost & i_req);
      w_any_win = w_ld_win | w_d_win | w_i_win;
   end

   assign ld_gnt = w_ld_win;
   assign d_gnt  = w_d_win;
   assign i_gnt  = w_i_win;

   always_comb begin
      w_starve_next = 4'd0;
      if (i_req && !w_i_win) begin
         w_starve_next = (r_starve_cnt == c_starve_limit) ? r_starve_cnt
                                                          : r_starve_cnt + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_starve_cnt <= 4'd0;
         r_boost      <= 1'b0;
      end else begin
         r_starve_cnt <= w_starve_next;
         r_boost      <= (w_starve_next == c_starve_limit);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_mem_en      <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_wdata   <= '0;
         r_mem_we      <= 2'b00;
         r_owner_fetch <= 1'b0;
      end else begin
         r_mem_en <= w_any_win;
         if (w_ld_win) begin
            r_mem_addr    <= ld_addr;
            r_mem_wdata   <= ld_wdata;
            r_mem_we      <= ld_we;
            r_owner_fetch <= 1'b0;
         end else if (w_d_win) begin
            r_mem_addr    <= d_addr;
            r_mem_wdata   <= d_wdata;
            r_mem_we      <= d_we;
            r_owner_fetch <= 1'b0;
         end else if (w_i_win) begin
            r_mem_addr    <= i_addr & c_fetch_mask;
            r_mem_wdata   <= '0;
            r_mem_we      <= 2'b00;
            r_owner_fetch <= 1'b1;
         end
      end
   end

   // Tag enters with the strobe so its last stage lines up with mem_rdata.
   assign w_tag_in_v = r_mem_en & (r_mem_we == 2'b00);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_tag_v  <= '0;
         r_tag_f  <= '0;
         r_tag_hi <= '0;
      end else begin
         r_tag_v[0]  <= w_tag_in_v;
         r_tag_f[0]  <= r_owner_fetch;
         r_tag_hi[0] <= r_mem_addr[2];
         for (int k = 1; k < MEM_LAT; k++) begin
            r_tag_v[k]  <= r_tag_v[k-1];
            r_tag_f[k]  <= r_tag_f[k-1];
            r_tag_hi[k] <= r_tag_hi[k-1];
         end
      end
   end

   assign w_ret_v  = ~reset & r_tag_v[MEM_LAT-1];
   assign d_rvalid = w_ret_v & ~r_tag_f[MEM_LAT-1];
   assign i_rvalid = w_ret_v & r_tag_f[MEM_LAT-1];
   assign d_rdata  = d_rvalid ? mem_rdata : 64'd0;
   assign i_rdata  = !i_rvalid ? 32'd0 :
                     (r_tag_hi[MEM_LAT-1] ? mem_rdata[63:32] : mem_rdata[31:0]);

   assign mem_en    = r_mem_en;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign mem_we    = r_mem_we;
   assign busy      = r_mem_en | (|r_tag_v);

endmodule
`default_nettype wire
